// File: rtl/bit_serial_alu_ctrl_pkg.sv
// Shared opcode constants, FSM state type and opcode helpers for the bit-serial ALU.
package bit_serial_alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_SLT  = 3'b011;
    localparam logic [OP_W-1:0] OP_AND  = 3'b100;
    localparam logic [OP_W-1:0] OP_NAND = 3'b101;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b110;
    localparam logic [OP_W-1:0] OP_OR   = 3'b111;

    // Ops that run through the adder and thread a carry between bits.
    function automatic logic op_is_arith(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // Ops that compute a + ~b + 1.
    function automatic logic op_inverts_b(input logic [OP_W-1:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/bit_serial_alu_ctrl_slice.sv
// One-bit ALU slice: full adder for arithmetic ops, bitwise gates for logic ops.
module alu_bit_slice
    import bit_serial_alu_ctrl_pkg::*;
(
    input  logic            a,
    input  logic            b,
    input  logic            cin,
    input  logic [OP_W-1:0] op,
    output logic            out,
    output logic            cout
);

    logic bx;

    // Bit operation select; carry is only meaningful for arithmetic ops.
    always_comb begin
        bx   = op_inverts_b(op) ? ~b : b;
        out  = 1'b0;
        cout = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_SLT: begin
                out  = a ^ bx ^ cin;
                cout = (a & bx) | (a & cin) | (bx & cin);
            end
            OP_XOR:  out = a ^ b;
            OP_AND:  out = a & b;
            OP_NAND: out = ~(a & b);
            OP_NOR:  out = ~(a | b);
            OP_OR:   out = a | b;
            default: out = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs a WIDTH-bit op through one 1-bit slice, LSB first.
module bit_serial_alu_ctrl
    import bit_serial_alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OP_W-1:0]  op_q;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic [WIDTH-2:0] shift_q;

    logic             slice_out;
    logic             slice_cout;
    logic             arith;
    logic             ovf_c;
    logic [WIDTH-1:0] final_c;

    alu_bit_slice u_slice (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry_q),
        .op   (op_q),
        .out  (slice_out),
        .cout (slice_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is honoured only in IDLE and DONE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (idx == LAST_IDX) begin
                    last_bit  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Final value assembly on the MSB cycle; SLT collapses to sign XOR overflow.
    always_comb begin
        arith   = op_is_arith(op_q);
        ovf_c   = carry_q ^ slice_cout;
        final_c = {slice_out, shift_q};
        if (op_q == OP_SLT) begin
            final_c = WIDTH'(slice_out ^ ovf_c);
        end
    end

    // Operand latch, bit sequencing and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx      <= '0;
            carry_q  <= 1'b0;
            shift_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            busy <= (state_nxt == ST_RUN);
            done <= (state_nxt == ST_DONE);
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                op_q    <= op;
                idx     <= '0;
                carry_q <= op_inverts_b(op);
                shift_q <= '0;
            end else if (state == ST_RUN) begin
                shift_q <= (WIDTH-1)'({slice_out, shift_q} >> 1);
                idx     <= idx + IDX_W'(1);
                if (arith) begin
                    carry_q <= slice_cout;
                end
                if (last_bit) begin
                    result   <= final_c;
                    carryout <= arith & slice_cout;
                    overflow <= arith & ovf_c;
                    zero     <= (final_c == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Scoreboard bench for bit_serial_alu_ctrl (WIDTH = 32).
module tb_bit_serial_alu_ctrl;

    localparam int unsigned W = 32;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SUB  = 3'b001;
    localparam logic [2:0] XOR_ = 3'b010;
    localparam logic [2:0] SLT  = 3'b011;
    localparam logic [2:0] AND_ = 3'b100;
    localparam logic [2:0] NAND = 3'b101;
    localparam logic [2:0] NOR_ = 3'b110;
    localparam logic [2:0] OR_  = 3'b111;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carryout, overflow, zero;
    logic [W-1:0] result;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   done_cyc = 0;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carryout (carryout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model built from plain wide arithmetic.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t       e;
        logic [W:0] s;
        e = '0;
        case (o)
            ADD: begin
                s     = {1'b0, x} + {1'b0, y};
                e.res = s[W-1:0];
                e.c   = s[W];
                e.v   = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
            end
            SUB, SLT: begin
                s     = {1'b0, x} + {1'b0, ~y} + 33'd1;
                e.res = s[W-1:0];
                e.c   = s[W];
                e.v   = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
                if (o == SLT) e.res = {31'd0, ($signed(x) < $signed(y))};
            end
            XOR_: e.res = x ^ y;
            AND_: e.res = x & y;
            NAND: e.res = ~(x & y);
            NOR_: e.res = ~(x | y);
            default: e.res = x | y;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Scoreboard pop on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            done_cyc <= cyc;
            check_eq("busy_low_at_done", 64'(busy), 64'd0);
            if (sb.size() == 0) begin
                check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            end else begin
                e = sb.pop_front();
                check_eq("result",   64'(result),   64'(e.res));
                check_eq("carryout", 64'(carryout), 64'(e.c));
                check_eq("overflow", 64'(overflow), 64'(e.v));
                check_eq("zero",     64'(zero),     64'(e.z));
            end
        end
    end

    // One op with latency/busy/pulse checks; optional stray start mid-run.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit glitch);
        int acc, nb;
        bit got;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        sb.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0;
        acc = cyc; nb = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) nb++;
                if (glitch && i == 5) begin
                    start = 1'b1; op = ADD; a = 32'h1234_5678; b = 32'h1111_1111;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        check_eq("done_seen", 64'(got), 64'd1);
        check_eq("latency", 64'(cyc - acc), 64'd32);
        check_eq("busy_cycles", 64'(nb), 64'd32);
        @(negedge clk);
        check_eq("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check_eq(tag, 64'(got), 64'd1);
    endtask

    initial begin
        int d1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_flags", 64'({carryout, overflow, zero}), 64'd0);
        reset = 1'b0;

        run_op(ADD, 32'h0000_0005, 32'h0000_0003, 1'b0);
        run_op(SUB, 32'd5, 32'd5, 1'b0);
        run_op(ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
        run_op(ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(SLT, 32'h8000_0000, 32'd1, 1'b0);
        run_op(SLT, 32'd1, 32'hFFFF_FFFF, 1'b0);
        run_op(SLT, 32'd7, 32'd7, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k != 0 && k != 1 && k != 3) run_op(3'(k), 32'hF0F0_1234, 32'hFF00_FF00, 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
        end

        // Stray start mid-run must be ignored.
        run_op(SUB, 32'h0000_1000, 32'h0000_0001, 1'b1);

        // Start held through DONE: second op accepted on the edge after done rises.
        @(negedge clk);
        op = ADD; a = 32'd100; b = 32'd23; start = 1'b1;
        sb.push_back(model(ADD, 32'd100, 32'd23));
        wait_done("b2b_first_done");
        d1 = cyc;
        op = XOR_; a = 32'hAAAA_5555; b = 32'h0F0F_0F0F;
        sb.push_back(model(XOR_, 32'hAAAA_5555, 32'h0F0F_0F0F));
        @(negedge clk);
        start = 1'b0;
        check_eq("b2b_busy_rise", 64'(busy), 64'd1);
        check_eq("b2b_done_fall", 64'(done), 64'd0);
        wait_done("b2b_second_done");
        check_eq("b2b_period", 64'(cyc - d1), 64'd33);
        @(negedge clk);

        // Reset during bit 10 aborts the op; outputs clear on the next edge.
        @(negedge clk);
        op = SUB; a = 32'h0000_0F00; b = 32'h0000_0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_result", 64'(result), 64'd0);
        check_eq("abort_flags", 64'({carryout, overflow, zero}), 64'd0);
        repeat (40) @(negedge clk);
        check_eq("abort_no_done", 64'(done), 64'd0);
        run_op(ADD, 32'h1234_0000, 32'h0000_5678, 1'b0);

        repeat (2) @(negedge clk);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
